// File: rtl/sort4_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sort4_controller_pkg
// Description : Shared types and constants for the nibble bubble-sort
//               sequencer: FSM state encoding and comparator result bits.
// Revision    : 1.0 - initial release
// ============================================================================
package sort4_controller_pkg;

  // Controller states; any other encoding is treated as LOAD.
  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SORT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Bit positions inside the comparator result vector {gt, eq, lt}.
  localparam int GT = 2;
  localparam int EQ = 1;
  localparam int LT = 0;

endpackage
`default_nettype wire

// File: rtl/sort4_controller_mag_compare.sv
`default_nettype none
// ============================================================================
// Module      : mag_compare
// Description : Unsigned magnitude comparator, result {gt, eq, lt} of a vs b.
// Revision    : 1.0 - initial release
// ============================================================================
module mag_compare
  import sort4_controller_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [2:0]       r
);

  // Exactly one result bit is set for any pair of operands.
  always_comb begin
    r     = '0;
    r[GT] = (a > b);
    r[EQ] = (a == b);
    r[LT] = (a < b);
  end

endmodule
`default_nettype wire

// File: rtl/sort4_controller.sv
`default_nettype none
// ============================================================================
// Module      : sort4_controller
// Description : Loads a block of DEPTH nibbles over a valid/ready port,
//               bubble-sorts it in place with one shared comparator (one
//               compare-and-swap per clock), then drains it over a
//               valid/ready port, index 0 first.
// Revision    : 1.0 - initial release
// ============================================================================
module sort4_controller
  import sort4_controller_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int DEPTH  = 4,
  parameter int ASCEND = 1,
  parameter int CNT_W  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] swap_count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] c_last_idx  = IDX_W'(DEPTH - 1);
  localparam logic [IDX_W-1:0] c_last_pass = IDX_W'(DEPTH - 2);
  localparam logic [IDX_W-1:0] c_idx_one   = IDX_W'(1);
  localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);

  state_t           r_state;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] r_pass;
  logic [IDX_W-1:0] r_j;
  logic             r_no_swap;
  logic [CNT_W-1:0] r_swap_count;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_out_last;
  logic             r_busy;
  logic             r_done;

  logic [IDX_W-1:0] w_j_nxt;
  logic [IDX_W-1:0] w_j_end;
  logic [IDX_W-1:0] w_idx_nxt;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [2:0]       w_cmp;
  logic             w_swap;
  logic             w_pass_clean;

  // The pass shrinks by one element each time: the largest (or smallest)
  // remaining value has bubbled to the end of the unsorted region.
  assign w_j_nxt   = r_j + c_idx_one;
  assign w_j_end   = c_last_pass - r_pass;
  assign w_idx_nxt = r_idx + c_idx_one;

  assign w_a = r_mem[r_j];
  assign w_b = r_mem[w_j_nxt];

  mag_compare #(
    .WIDTH (WIDTH)
  ) u_cmp (
    .a (w_a),
    .b (w_b),
    .r (w_cmp)
  );

  // Equal pairs never swap, which keeps the sort stable.
  assign w_swap = (r_state == SORT) && !w_cmp[EQ] &&
                  ((ASCEND != 0) ? w_cmp[GT] : w_cmp[LT]);

  // A pass is clean only if neither earlier compares nor this one swapped.
  assign w_pass_clean = r_no_swap && !w_swap;

  // Main sequencer: storage, indices, counters and registered handshake flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= LOAD;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_idx        <= '0;
      r_pass       <= '0;
      r_j          <= '0;
      r_no_swap    <= 1'b1;
      r_swap_count <= '0;
      r_in_ready   <= 1'b1;
      r_out_valid  <= 1'b0;
      r_out_last   <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        LOAD: begin
          if (in_valid && r_in_ready) begin
            r_mem[r_idx] <= in_data;
            if (r_idx == '0) begin
              r_swap_count <= '0;
            end
            if (r_idx == c_last_idx) begin
              r_state    <= SORT;
              r_idx      <= '0;
              r_pass     <= '0;
              r_j        <= '0;
              r_no_swap  <= 1'b1;
              r_in_ready <= 1'b0;
              r_busy     <= 1'b1;
            end else begin
              r_idx <= w_idx_nxt;
            end
          end
        end

        SORT: begin
          if (w_swap) begin
            r_mem[r_j]     <= w_b;
            r_mem[w_j_nxt] <= w_a;
            r_swap_count   <= r_swap_count + c_cnt_one;
            r_no_swap      <= 1'b0;
          end
          if (r_j == w_j_end) begin
            if (w_pass_clean || (r_pass == c_last_pass)) begin
              r_state     <= DRAIN;
              r_done      <= 1'b1;
              r_idx       <= '0;
              r_out_valid <= 1'b1;
              r_out_last  <= 1'b0;
            end else begin
              r_pass    <= r_pass + c_idx_one;
              r_j       <= '0;
              r_no_swap <= 1'b1;
            end
          end else begin
            r_j <= w_j_nxt;
          end
        end

        DRAIN: begin
          if (r_out_valid && out_ready) begin
            if (r_out_last) begin
              r_state     <= LOAD;
              r_idx       <= '0;
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
              r_busy      <= 1'b0;
              r_in_ready  <= 1'b1;
            end else begin
              r_idx      <= w_idx_nxt;
              r_out_last <= (w_idx_nxt == c_last_idx);
            end
          end
        end

        default: begin
          r_state     <= LOAD;
          r_idx       <= '0;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_out_last  <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_valid ? r_mem[r_idx] : '0;
  assign out_last   = r_out_last;
  assign busy       = r_busy;
  assign done       = r_done;
  assign swap_count = r_swap_count;

endmodule
`default_nettype wire

// File: tb/tb_sort4_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_sort4_controller
// Description : Directed, table-driven bench for sort4_controller with one
//               ascending and one descending instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sort4_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid_a;
  logic       in_valid_d;
  logic [3:0] in_data;
  logic       out_ready;

  logic       in_ready_a, out_valid_a, out_last_a, busy_a, done_a;
  logic [3:0] out_data_a;
  logic [2:0] swap_count_a;
  logic       in_ready_d, out_valid_d, out_last_d, busy_d, done_d;
  logic [3:0] out_data_d;
  logic [2:0] swap_count_d;

  logic       use_d;
  int         n_vec = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  sort4_controller #(.WIDTH(4), .DEPTH(4), .ASCEND(1), .CNT_W(3)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_data(in_data), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_data(out_data_a), .out_last(out_last_a), .busy(busy_a),
    .done(done_a), .swap_count(swap_count_a)
  );

  sort4_controller #(.WIDTH(4), .DEPTH(4), .ASCEND(0), .CNT_W(3)) dut_d (
    .clk(clk), .rst(rst), .in_valid(in_valid_d), .in_ready(in_ready_d),
    .in_data(in_data), .out_valid(out_valid_d), .out_ready(out_ready),
    .out_data(out_data_d), .out_last(out_last_d), .busy(busy_d),
    .done(done_d), .swap_count(swap_count_d)
  );

  // Views of whichever instance the current test targets.
  logic       s_in_ready, s_out_valid, s_out_last, s_busy, s_done;
  logic [3:0] s_out_data;
  logic [2:0] s_swap_count;
  assign s_in_ready   = use_d ? in_ready_d   : in_ready_a;
  assign s_out_valid  = use_d ? out_valid_d  : out_valid_a;
  assign s_out_last   = use_d ? out_last_d   : out_last_a;
  assign s_busy       = use_d ? busy_d       : busy_a;
  assign s_done       = use_d ? done_d       : done_a;
  assign s_out_data   = use_d ? out_data_d   : out_data_a;
  assign s_swap_count = use_d ? swap_count_d : swap_count_a;

  typedef struct packed {
    logic            d;     // 1 = descending instance
    logic            hold;  // keep in_valid high through SORT/DRAIN
    logic            tog;   // out_ready pattern 1,0,0,1,0,0,...
    logic [3:0][3:0] din;
    logic [3:0][3:0] exp;
    logic [2:0]      sw;
    logic [7:0]      cyc;
  } vec_t;

  vec_t vecs [5];

  function automatic vec_t mk(input logic d, input logic hold, input logic tog,
                              input logic [3:0] a0, input logic [3:0] a1,
                              input logic [3:0] a2, input logic [3:0] a3,
                              input logic [3:0] e0, input logic [3:0] e1,
                              input logic [3:0] e2, input logic [3:0] e3,
                              input logic [2:0] sw, input logic [7:0] cyc);
    vec_t v;
    v.d = d; v.hold = hold; v.tog = tog;
    v.din = {a3, a2, a1, a0};
    v.exp = {e3, e2, e1, e0};
    v.sw = sw; v.cyc = cyc;
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_valid(input logic d, input logic val);
    if (d) in_valid_d = val;
    else   in_valid_a = val;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_block(input vec_t v);
    int t;
    int cnt;
    int e;
    int p;
    use_d = v.d;
    t = 0;
    while (s_in_ready !== 1'b1 && t < 20) begin
      tick();
      t++;
    end
    check("in_ready_before_load", s_in_ready, 1);
    for (int k = 0; k < 4; k++) begin
      drive_valid(v.d, 1'b1);
      in_data = v.din[k];
      tick();
      if (k == 0) check("swap_count_cleared", s_swap_count, 0);
    end
    if (v.hold) in_data = 4'hF;
    else drive_valid(v.d, 1'b0);
    check("sort_busy", s_busy, 1);
    check("sort_in_ready", s_in_ready, 0);
    check("sort_out_valid", s_out_valid, 0);
    cnt = 0;
    while (s_done !== 1'b1 && cnt < 40) begin
      tick();
      cnt++;
    end
    check("sort_cycles", 8'(cnt), v.cyc);
    check("swap_count", s_swap_count, v.sw);
    e = 0;
    p = 0;
    while (e < 4 && p < 60) begin
      check("drain_out_valid", s_out_valid, 1);
      check("drain_out_data", s_out_data, v.exp[e]);
      check("drain_out_last", s_out_last, (e == 3));
      check("drain_busy", s_busy, 1);
      if (p > 0) check("done_one_cycle", s_done, 0);
      out_ready = v.tog ? ((p % 3) == 0) : 1'b1;
      tick();
      if (out_ready) e++;
      p++;
    end
    if (e < 4) check("drain_timeout", 8'(e), 4);
    out_ready = 1'b1;
    drive_valid(v.d, 1'b0);
    check("after_last_in_ready", s_in_ready, 1);
    check("after_last_out_valid", s_out_valid, 0);
    check("after_last_busy", s_busy, 0);
    check("swap_count_held", s_swap_count, v.sw);
    tick();
    check("idle_in_ready", s_in_ready, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, s_in_ready, 1);
    check({tag, "_out_valid"}, s_out_valid, 0);
    check({tag, "_out_data"}, s_out_data, 0);
    check({tag, "_out_last"}, s_out_last, 0);
    check({tag, "_busy"}, s_busy, 0);
    check({tag, "_done"}, s_done, 0);
    check({tag, "_swap_count"}, s_swap_count, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = mk(0, 0, 0, 9, 3, 7, 1,  1, 3, 7, 9,  3'd5, 8'd6);
    vecs[1] = mk(0, 0, 0, 1, 2, 3, 4,  1, 2, 3, 4,  3'd0, 8'd3);
    vecs[2] = mk(0, 0, 1, 5, 5, 2, 5,  2, 5, 5, 5,  3'd2, 8'd6);
    vecs[3] = mk(1, 1, 0, 0, 15, 8, 8, 15, 8, 8, 0, 3'd3, 8'd5);
    vecs[4] = mk(0, 0, 0, 4, 2, 3, 1,  1, 2, 3, 4,  3'd5, 8'd6);

    rst = 1'b1;
    in_valid_a = 1'b0;
    in_valid_d = 1'b0;
    in_data = 4'd0;
    out_ready = 1'b1;
    use_d = 1'b0;
    #12;
    check_reset_outputs("reset_a");
    use_d = 1'b1;
    check_reset_outputs("reset_d");
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();

    for (int i = 0; i < 4; i++) begin
      run_block(vecs[i]);
    end

    // Reset after two compares of a block in SORT.
    use_d = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid_a = 1'b1;
      in_data = vecs[0].din[k];
      tick();
    end
    in_valid_a = 1'b0;
    tick();
    tick();
    check("midsort_busy", s_busy, 1);
    check("midsort_swaps", s_swap_count, 2);
    rst = 1'b1;
    #1;
    check_reset_outputs("midsort_reset");
    @(posedge clk);
    #1;
    check_reset_outputs("midsort_reset_held");
    rst = 1'b0;
    tick();
    check_reset_outputs("after_reset_idle");
    run_block(vecs[4]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
